// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - Multi-cycle multiply/divide unit owning the HI/LO registers.
// Optional div_zero output port enabled by defining DIVZERO_FLAG_EN.
module muldiv_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
`ifdef DIVZERO_FLAG_EN
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
`else
  output logic [WIDTH-1:0] lo
`endif
);

  localparam int CW = $clog2(WIDTH + MUL_STAGES + 1);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV_INIT, S_DIV_ITER, S_DIV_FIX} state_t;

  state_t             r_state, w_next;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_ma, r_mb, r_quo, r_rem, r_div, r_hi, r_lo;
  logic               r_signed, r_neg_q, r_neg_r, r_dz, r_done, r_div_zero;
  logic [2*WIDTH-1:0] r_pipe [MUL_STAGES];

  logic               w_res_we, w_accept;
  logic [WIDTH-1:0]   w_res_hi, w_res_lo, w_abs_a, w_abs_b;
  logic [2*WIDTH-1:0] w_ma_ext, w_mb_ext, w_prod;
  logic [WIDTH:0]     w_sh, w_diff;

  assign busy = (r_state != S_IDLE) || r_done;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;
`ifdef DIVZERO_FLAG_EN
  assign div_zero = r_div_zero;
`endif

  assign w_ma_ext = r_signed ? {{WIDTH{r_ma[WIDTH-1]}}, r_ma} : {{WIDTH{1'b0}}, r_ma};
  assign w_mb_ext = r_signed ? {{WIDTH{r_mb[WIDTH-1]}}, r_mb} : {{WIDTH{1'b0}}, r_mb};
  assign w_prod   = w_ma_ext * w_mb_ext;

  assign w_abs_a  = (r_signed && r_ma[WIDTH-1]) ? -r_ma : r_ma;
  assign w_abs_b  = (r_signed && r_mb[WIDTH-1]) ? -r_mb : r_mb;
  // Restoring step: shift next dividend bit into the partial remainder, try the subtract.
  assign w_sh     = {r_rem, r_quo[WIDTH-1]};
  assign w_diff   = w_sh - {1'b0, r_div};
  assign w_accept = (r_state == S_IDLE) && (w_next != S_IDLE);

  always_comb begin
    w_next   = r_state;
    w_res_we = 1'b0;
    w_res_hi = '0;
    w_res_lo = '0;
    unique case (r_state)
      S_IDLE:     if (start && !r_done) w_next = op[1] ? S_DIV_INIT : S_MUL;
      S_MUL: begin
        {w_res_hi, w_res_lo} = r_pipe[MUL_STAGES-1];
        if (r_cnt == CW'(MUL_STAGES)) begin
          w_next   = S_IDLE;
          w_res_we = 1'b1;
        end
      end
      S_DIV_INIT: w_next = S_DIV_ITER;
      S_DIV_ITER: if (r_cnt == CW'(WIDTH - 1)) w_next = S_DIV_FIX;
      S_DIV_FIX: begin
        w_res_lo = r_dz ? '1 : (r_neg_q ? -r_quo : r_quo);
        w_res_hi = r_neg_r ? -r_rem : r_rem;
        w_next   = S_IDLE;
        w_res_we = 1'b1;
      end
      default:    w_next = S_IDLE;
    endcase
    if (flush) begin
      w_next   = S_IDLE;
      w_res_we = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_ma       <= '0;
      r_mb       <= '0;
      r_signed   <= 1'b0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_div      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dz       <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      for (int i = 0; i < MUL_STAGES; i++) r_pipe[i] <= '0;
    end else begin
      r_state    <= w_next;
      r_done     <= w_res_we;
      r_div_zero <= w_res_we && (r_state == S_DIV_FIX) && r_dz;
      r_cnt      <= ((r_state == S_MUL || r_state == S_DIV_ITER) && w_next == r_state) ?
                    r_cnt + 1'b1 : '0;
      r_pipe[0]  <= w_prod;
      for (int i = 1; i < MUL_STAGES; i++) r_pipe[i] <= r_pipe[i-1];
      if (w_accept) begin
        r_ma     <= a;
        r_mb     <= b;
        r_signed <= ~op[0];
      end
      if (r_state == S_DIV_INIT) begin
        r_quo   <= w_abs_a;
        r_div   <= w_abs_b;
        r_rem   <= '0;
        r_dz    <= (r_mb == '0);
        r_neg_q <= r_signed && (r_ma[WIDTH-1] ^ r_mb[WIDTH-1]);
        r_neg_r <= r_signed && r_ma[WIDTH-1];
      end else if (r_state == S_DIV_ITER) begin
        if (!w_diff[WIDTH]) begin
          r_rem <= w_diff[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], 1'b1};
        end else begin
          r_rem <= w_sh[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], 1'b0};
        end
      end
      // A same-edge MTHI/MTLO is the younger instruction and overrides the result.
      if (wr_hi)         r_hi <= wr_data;
      else if (w_res_we) r_hi <= w_res_hi;
      if (wr_lo)         r_lo <= wr_data;
      else if (w_res_we) r_lo <= w_res_lo;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - Directed vector bench for muldiv_unit.
module tb_muldiv_unit;

  logic        clk, rst_n, start, flush, wr_hi, wr_lo;
  logic [1:0]  op;
  logic [31:0] a, b, wr_data, hi, lo;
  logic        busy, done;
`ifdef DIVZERO_FLAG_EN
  logic        div_zero;
`endif

  muldiv_unit #(.WIDTH(32), .MUL_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
    .busy(busy), .done(done), .hi(hi),
`ifdef DIVZERO_FLAG_EN
    .lo(lo), .div_zero(div_zero)
`else
    .lo(lo)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    logic        dz;
  } vec_t;

  vec_t vecs[12];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after edge 0; returns the edge number on which done was seen.
  task automatic wait_done(input int from, output int lat, output logic busy_ok);
    lat     = from;
    busy_ok = 1'b1;
    while (!done && lat < 100) begin
      if (!busy) busy_ok = 1'b0;
      tick();
      lat++;
    end
  endtask

  int          lat;
  logic        bok, seen_done;
  logic [31:0] keep_hi, keep_lo;

  initial begin
    vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 3, 1'b0};
    vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 3, 1'b0};
    vecs[2]  = '{2'b00, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 3, 1'b0};
    vecs[3]  = '{2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 3, 1'b0};
    vecs[4]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 34, 1'b0};
    vecs[5]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       34, 1'b0};
    vecs[6]  = '{2'b11, 32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF, 34, 1'b1};
    vecs[7]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34, 1'b0};
    vecs[8]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 34, 1'b0};
    vecs[9]  = '{2'b10, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 34, 1'b1};
    vecs[10] = '{2'b11, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 34, 1'b0};
    vecs[11] = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 34, 1'b0};

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    op = 2'b00; a = '0; b = '0; wr_data = '0;
    tick(); tick();
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      op = vecs[i].op; a = vecs[i].a; b = vecs[i].b; start = 1'b1;
      tick();
      start = 1'b0; a = $urandom; b = $urandom;
      wait_done(0, lat, bok);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_busy_before_done", i), 32'(bok), 32'h1);
      chk($sformatf("v%0d_busy_at_done", i), 32'(busy), 32'h1);
      chk($sformatf("v%0d_hi", i), hi, vecs[i].hi);
      chk($sformatf("v%0d_lo", i), lo, vecs[i].lo);
`ifdef DIVZERO_FLAG_EN
      chk($sformatf("v%0d_div_zero", i), 32'(div_zero), 32'(vecs[i].dz));
`endif
      tick();
      chk($sformatf("v%0d_done_single", i), 32'(done), 32'h0);
      chk($sformatf("v%0d_busy_after", i), 32'(busy), 32'h0);
    end

    wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'hAAAA5555;
    tick();
    wr_hi = 1'b0; wr_lo = 1'b0;
    chk("mt_both_hi", hi, 32'hAAAA5555);
    chk("mt_both_lo", lo, 32'hAAAA5555);

    // DIV 1000/3 flushed mid-iteration; a MULT offered at edge 5 must be ignored.
    seen_done = 1'b0;
    op = 2'b10; a = 32'd1000; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 4; e++) begin tick(); seen_done |= done; end
    op = 2'b00; a = 32'd2; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    chk("flush_busy_e5", 32'(busy), 32'h1);
    for (int e = 6; e <= 10; e++) begin tick(); seen_done |= done; end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy_e11", 32'(busy), 32'h0);
    for (int e = 0; e < 40; e++) begin tick(); seen_done |= done; end
    chk("flush_no_done", 32'(seen_done), 32'h0);
    chk("flush_hi_kept", hi, 32'hAAAA5555);
    chk("flush_lo_kept", lo, 32'hAAAA5555);

    seen_done = 1'b0;
    op = 2'b11; a = 32'd9; b = 32'd2; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", 32'(busy), 32'h0);
    for (int e = 0; e < 40; e++) begin tick(); seen_done |= done; end
    chk("flush_start_no_done", 32'(seen_done), 32'h0);
    chk("flush_start_lo", lo, 32'hAAAA5555);

    // MTLO during a divide lands at once; the divide still completes and overwrites it.
    op = 2'b11; a = 32'd1000; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0; wr_lo = 1'b1; wr_data = 32'h0000DEAD;
    tick();
    wr_lo = 1'b0;
    chk("mtlo_inflight", lo, 32'h0000DEAD);
    wait_done(1, lat, bok);
    chk("mtlo_div_latency", 32'(lat), 32'd34);
    chk("mtlo_div_lo", lo, 32'd333);
    chk("mtlo_div_hi", hi, 32'd1);
    tick();

    op = 2'b00; a = 32'd3; b = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    wr_hi = 1'b1; wr_data = 32'h00001234;
    tick();
    wr_hi = 1'b0;
    chk("collide_done", 32'(done), 32'h1);
    chk("collide_hi", hi, 32'h00001234);
    chk("collide_lo", lo, 32'd15);
    tick();

    keep_hi = hi; keep_lo = lo;
    chk("pre_reset_lo_nonzero", 32'(keep_lo != 0), 32'h1);
    op = 2'b00; a = 32'hFFFFFFFF; b = 32'h00000005; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("async_rst_hi", hi, 32'h0);
    chk("async_rst_lo", lo, 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    chk("async_rst_done", 32'(done), 32'h0);
    tick();
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int e = 0; e < 10; e++) begin tick(); seen_done |= done; end
    chk("rst_no_done", 32'(seen_done), 32'h0);
    chk("rst_hi_stays", hi, 32'h0);
    chk("rst_lo_stays", lo, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
